// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and default constants for the run controller.
// Optional feature macro used by run_ctrl: RUN_CTRL_TRACE_EN.
package run_ctrl_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int RST_HOLD_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of the reset-hold down-counter; never narrower than one bit.
  function automatic int hold_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_hold_cnt.sv
// run_ctrl_hold_cnt: loadable down-counter that times the core reset window.
// The counter stops at zero; zero is the "hold finished" flag.
module run_ctrl_hold_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences parallel cores through reset, run and completion.
// Optional feature: define RUN_CTRL_TRACE_EN to add the halt_cycle output,
// which records the cycle count at which each channel halted.
//
// Handshake: start is a single-cycle request, accepted only in IDLE or DONE
// (no ready signal; requests in RESET/RUN are dropped). halt_in is a level
// that is only observed in RUN. dbg_state exposes the FSM state.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        fwd_mask,
  input  logic [CNT_W-1:0]         max_cycles,
  input  logic [NUM_CH-1:0]        halt_in,
  output logic [NUM_CH-1:0]        core_rst,
  output logic [NUM_CH-1:0]        forward_en,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
`ifdef RUN_CTRL_TRACE_EN
  output logic [NUM_CH*CNT_W-1:0]  halt_cycle,
`endif
  output state_t                   dbg_state
);

  localparam int HOLD_W = hold_w(RST_HOLD);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   halted_q;
  logic [CNT_W-1:0]    limit_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_CH-1:0]   fwd_q;
  logic                timeout_q;
  logic                start_ok;
  logic                all_halt;
  logic                limit_hit;
  logic                hold_zero;

  // A zero limit disables the timeout; otherwise the last RUN cycle is limit-1.
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign all_halt  = &(halted_q | halt_in);
  assign limit_hit = (limit_q != '0) && (cnt_q == (limit_q - CNT_W'(1)));

  run_ctrl_hold_cnt #(.W(HOLD_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .dec      (state_q == ST_RESET),
    .load_val (HOLD_W'(RST_HOLD - 1)),
    .zero     (hold_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; halting beats the limit when both occur together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok)              state_d = ST_RESET;
      ST_RESET:         if (hold_zero)             state_d = ST_RUN;
      ST_RUN:           if (all_halt || limit_hit) state_d = ST_DONE;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  // Run datapath: latch config on start, count and collect halts in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_q     <= '0;
      limit_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      halted_q  <= '0;
    end else if (start_ok) begin
      fwd_q     <= fwd_mask;
      limit_q   <= max_cycles;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      halted_q  <= '0;
    end else if (state_q == ST_RUN) begin
      if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      halted_q <= halted_q | halt_in;
      if (!all_halt && limit_hit) timeout_q <= 1'b1;
    end
  end

`ifdef RUN_CTRL_TRACE_EN
  logic [NUM_CH*CNT_W-1:0] trace_q;

  // Capture the cycle count at the first RUN cycle each channel reports halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_q <= '0;
    end else if (start_ok) begin
      trace_q <= '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (halt_in[i] && !halted_q[i]) trace_q[i*CNT_W +: CNT_W] <= cnt_q;
      end
    end
  end

  assign halt_cycle = trace_q;
`endif

  // Outputs decoded from the registered state.
  always_comb begin
    core_rst = '1;
    if (state_q == ST_RUN) core_rst = halted_q;
  end

  assign forward_en = fwd_q;
  assign cycle_cnt  = cnt_q;
  assign busy       = (state_q == ST_RESET) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule
